// File: rtl/maquina_rtc_rw.sv
`default_nettype none
// ============================================================================
//  Module   : maquina_rtc_rw
//  Purpose  : Burst read/write sequencer for a multiplexed address/data RTC
//             bus. Each register transfer is four timed phases: address
//             active, address recovery, data active, data recovery.
//  Revision : 1.0 - initial release
// ============================================================================
module maquina_rtc_rw #(
    parameter int                 N_REG     = 6,
    parameter int                 T_FASE    = 4,
    parameter logic [N_REG*8-1:0] DIR_TABLA = {8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Escritura,
    input  logic               Lectura,
    input  logic [N_REG*8-1:0] Datos_Esc,
    input  logic [7:0]         Dato_Dire_in,
    output logic               CS,
    output logic               WR,
    output logic               RD,
    output logic               AD,
    output logic [7:0]         Dato_Dire,
    output logic               Dato_oe,
    output logic [N_REG*8-1:0] Datos_Lec,
    output logic               Ocupado,
    output logic               Term_Esc,
    output logic               Term_Lec
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_DIR_ACT = 3'd1;
    localparam logic [2:0] c_ST_DIR_REC = 3'd2;
    localparam logic [2:0] c_ST_DAT_ACT = 3'd3;
    localparam logic [2:0] c_ST_DAT_REC = 3'd4;
    localparam logic [2:0] c_ST_FIN     = 3'd5;

    localparam logic [7:0] c_FASE_ULT = 8'(T_FASE - 1);
    localparam logic [3:0] c_IDX_ULT  = 4'(N_REG - 1);

    logic [2:0]         r_st;
    logic [7:0]         r_fase;
    logic [3:0]         r_idx;
    logic               r_modo;      // 1 = write burst, 0 = read burst
    logic               r_esc_ant;
    logic               r_lec_ant;
    logic [N_REG*8-1:0] r_snap;

    logic               w_esc_flanco;
    logic               w_lec_flanco;
    logic               w_req;
    logic               w_fase_fin;
    logic [2:0]         w_st_nx;
    logic [7:0]         w_fase_nx;
    logic [3:0]         w_idx_nx;
    logic               w_modo_nx;
    logic [7:0]         w_dir_byte;
    logic [7:0]         w_dat_byte;

    assign w_esc_flanco = Escritura & ~r_esc_ant;
    assign w_lec_flanco = Lectura & ~r_lec_ant;
    assign w_req        = w_esc_flanco | w_lec_flanco;
    assign w_fase_fin   = (r_fase == c_FASE_ULT);

    // Bytes selected by the upcoming register index, so the output registers
    // already carry the right address/data in the first cycle of a phase.
    assign w_dir_byte = 8'(DIR_TABLA >> {w_idx_nx, 3'b000});
    assign w_dat_byte = 8'(r_snap >> {w_idx_nx, 3'b000});

    // Next-state, phase counter and register index sequencing
    always_comb begin
        w_st_nx   = r_st;
        w_fase_nx = r_fase;
        w_idx_nx  = r_idx;
        w_modo_nx = r_modo;
        case (r_st)
            c_ST_IDLE: begin
                if (w_req) begin
                    w_st_nx   = c_ST_DIR_ACT;
                    w_fase_nx = 8'd0;
                    w_idx_nx  = 4'd0;
                    w_modo_nx = w_esc_flanco;   // write wins on a tie
                end
            end
            c_ST_DIR_ACT, c_ST_DIR_REC, c_ST_DAT_ACT, c_ST_DAT_REC: begin
                if (w_fase_fin) begin
                    w_fase_nx = 8'd0;
                    case (r_st)
                        c_ST_DIR_ACT: w_st_nx = c_ST_DIR_REC;
                        c_ST_DIR_REC: w_st_nx = c_ST_DAT_ACT;
                        c_ST_DAT_ACT: w_st_nx = c_ST_DAT_REC;
                        default: begin
                            if (r_idx < c_IDX_ULT) begin
                                w_idx_nx = r_idx + 4'd1;
                                w_st_nx  = c_ST_DIR_ACT;
                            end else begin
                                w_st_nx  = c_ST_FIN;
                            end
                        end
                    endcase
                end else begin
                    w_fase_nx = r_fase + 8'd1;
                end
            end
            c_ST_FIN: w_st_nx = c_ST_IDLE;
            default:  w_st_nx = c_ST_IDLE;
        endcase
    end

    // Control state, edge history and write-data snapshot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st      <= c_ST_IDLE;
            r_fase    <= 8'd0;
            r_idx     <= 4'd0;
            r_modo    <= 1'b0;
            r_esc_ant <= 1'b0;
            r_lec_ant <= 1'b0;
            r_snap    <= '0;
        end else begin
            r_st      <= w_st_nx;
            r_fase    <= w_fase_nx;
            r_idx     <= w_idx_nx;
            r_modo    <= w_modo_nx;
            r_esc_ant <= Escritura;
            r_lec_ant <= Lectura;
            if ((r_st == c_ST_IDLE) && w_esc_flanco) begin
                r_snap <= Datos_Esc;
            end
        end
    end

    // Registered bus strobes and status, decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CS        <= 1'b1;
            WR        <= 1'b1;
            RD        <= 1'b1;
            AD        <= 1'b1;
            Dato_Dire <= 8'd0;
            Dato_oe   <= 1'b0;
            Ocupado   <= 1'b0;
            Term_Esc  <= 1'b0;
            Term_Lec  <= 1'b0;
        end else begin
            CS        <= 1'b1;
            WR        <= 1'b1;
            RD        <= 1'b1;
            AD        <= 1'b1;
            Dato_Dire <= 8'd0;
            Dato_oe   <= 1'b0;
            Ocupado   <= (w_st_nx != c_ST_IDLE);
            Term_Esc  <= (w_st_nx == c_ST_FIN) &  w_modo_nx;
            Term_Lec  <= (w_st_nx == c_ST_FIN) & ~w_modo_nx;
            case (w_st_nx)
                c_ST_DIR_ACT: begin
                    CS        <= 1'b0;
                    WR        <= 1'b0;
                    AD        <= 1'b0;
                    Dato_Dire <= w_dir_byte;
                    Dato_oe   <= 1'b1;
                end
                c_ST_DAT_ACT: begin
                    CS <= 1'b0;
                    if (w_modo_nx) begin
                        WR        <= 1'b0;
                        Dato_Dire <= w_dat_byte;
                        Dato_oe   <= 1'b1;
                    end else begin
                        RD <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read capture: only the final cycle of a read data phase is sampled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Datos_Lec <= '0;
        end else if ((r_st == c_ST_DAT_ACT) && !r_modo && w_fase_fin) begin
            for (int b = 0; b < N_REG; b++) begin
                if (r_idx == 4'(b)) begin
                    Datos_Lec[b*8 +: 8] <= Dato_Dire_in;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maquina_rtc_rw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maquina_rtc_rw
//  Purpose  : Self-checking bench for maquina_rtc_rw. Two instances: the
//             default configuration and a minimal one (N_REG=1, T_FASE=1).
//             A timeline model predicts every output from burst position.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maquina_rtc_rw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        esc = 1'b0;
    logic        lec = 1'b0;
    logic [47:0] dat_esc = '0;
    logic [7:0]  din = 8'd0;

    logic        cs0, wr0, rd0, ad0, oe0, ocu0, te0, tl0;
    logic [7:0]  dd0;
    logic [47:0] lec0;
    logic        cs1, wr1, rd1, ad1, oe1, ocu1, te1, tl1;
    logic [7:0]  dd1;
    logic [7:0]  lec1;

    always #5 clk = ~clk;

    maquina_rtc_rw u_dut0 (
        .clk(clk), .reset(rst), .Escritura(esc), .Lectura(lec),
        .Datos_Esc(dat_esc), .Dato_Dire_in(din),
        .CS(cs0), .WR(wr0), .RD(rd0), .AD(ad0), .Dato_Dire(dd0), .Dato_oe(oe0),
        .Datos_Lec(lec0), .Ocupado(ocu0), .Term_Esc(te0), .Term_Lec(tl0)
    );

    maquina_rtc_rw #(.N_REG(1), .T_FASE(1), .DIR_TABLA(8'h21)) u_dut1 (
        .clk(clk), .reset(rst), .Escritura(esc), .Lectura(lec),
        .Datos_Esc(dat_esc[7:0]), .Dato_Dire_in(din),
        .CS(cs1), .WR(wr1), .RD(rd1), .AD(ad1), .Dato_Dire(dd1), .Dato_oe(oe1),
        .Datos_Lec(lec1), .Ocupado(ocu1), .Term_Esc(te1), .Term_Lec(tl1)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    // Reference model: burst position counted in cycles since DIR_ACT start
    int          pN[2] = '{6, 1};
    int          pT[2] = '{4, 1};
    logic        m_busy[2];
    int          m_pos[2];
    logic        m_wr[2];
    logic [47:0] m_snap[2];
    logic [47:0] m_lec[2];
    logic        m_pe[2];
    logic        m_pl[2];
    int          tesc_cnt[2];
    int          tlec_cnt[2];

    logic        rtc_mode = 1'b0;
    logic [7:0]  rtc_addr = 8'h21;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_reset(input int m);
        m_busy[m] = 1'b0;
        m_pos[m]  = 0;
        m_wr[m]   = 1'b0;
        m_snap[m] = '0;
        m_lec[m]  = '0;
        m_pe[m]   = 1'b0;
        m_pl[m]   = 1'b0;
    endtask

    // Advance the model by one cycle using the inputs that were just sampled
    task automatic model_step(input int m);
        logic ee, le;
        int   L, pair, ph;
        if (rst) begin
            model_reset(m);
            return;
        end
        ee = esc & ~m_pe[m];
        le = lec & ~m_pl[m];
        m_pe[m] = esc;
        m_pl[m] = lec;
        L = 4 * pN[m] * pT[m];
        if (m_busy[m]) begin
            if (m_pos[m] < L) begin
                pair = m_pos[m] / (4 * pT[m]);
                ph   = (m_pos[m] / pT[m]) % 4;
                if (!m_wr[m] && ph == 2 && (m_pos[m] % pT[m]) == pT[m] - 1)
                    m_lec[m][pair*8 +: 8] = din;
            end
            m_pos[m]++;
            if (m_pos[m] > L) m_busy[m] = 1'b0;
        end else if (ee || le) begin
            m_busy[m] = 1'b1;
            m_pos[m]  = 0;
            m_wr[m]   = ee;
            m_snap[m] = (m == 0) ? dat_esc : {40'h0, dat_esc[7:0]};
        end
    endtask

    task automatic check_dut(input int m);
        logic       ocs, owr, ord, oad, ooe, oocu, ote, otl;
        logic [7:0] odd;
        logic [47:0] olec;
        logic [4:0] exp5;
        int         L, pair, ph;
        string      p;
        if (m == 0) begin
            ocs = cs0; owr = wr0; ord = rd0; oad = ad0; ooe = oe0;
            oocu = ocu0; ote = te0; otl = tl0; odd = dd0; olec = lec0;
            p = "d0";
        end else begin
            ocs = cs1; owr = wr1; ord = rd1; oad = ad1; ooe = oe1;
            oocu = ocu1; ote = te1; otl = tl1; odd = dd1; olec = {40'h0, lec1};
            p = "d1";
        end
        L = 4 * pN[m] * pT[m];
        if (ote) tesc_cnt[m]++;
        if (otl) tlec_cnt[m]++;
        chk({p, "_ocupado"}, 64'(oocu), 64'(m_busy[m]));
        chk({p, "_term_esc"}, 64'(ote), 64'(m_busy[m] && m_pos[m] == L && m_wr[m]));
        chk({p, "_term_lec"}, 64'(otl), 64'(m_busy[m] && m_pos[m] == L && !m_wr[m]));
        chk({p, "_datos_lec"}, 64'(olec), 64'(m_lec[m]));
        if (!m_busy[m]) begin
            chk({p, "_idle_strobes"}, 64'({ocs, owr, ord, oad, ooe}), 64'(5'b11110));
            chk({p, "_idle_bus"}, 64'(odd), 64'(8'h00));
        end else if (m_pos[m] < L) begin
            pair = m_pos[m] / (4 * pT[m]);
            ph   = (m_pos[m] / pT[m]) % 4;
            case (ph)
                0: begin
                    exp5 = 5'b00101;
                    chk({p, "_addr"}, 64'(odd), 64'(8'h21 + 8'(pair)));
                end
                2: begin
                    if (m_wr[m]) begin
                        exp5 = 5'b00111;
                        chk({p, "_wdata"}, 64'(odd), 64'(m_snap[m][pair*8 +: 8]));
                    end else begin
                        exp5 = 5'b01010;
                    end
                end
                default: begin
                    exp5 = 5'b11110;
                    chk({p, "_rec_bus"}, 64'(odd), 64'(8'h00));
                end
            endcase
            chk({p, "_strobes"}, 64'({ocs, owr, ord, oad, ooe}), 64'(exp5));
        end
    endtask

    // One clock: step model on sampled inputs, then compare the new outputs
    task automatic cyc();
        @(posedge clk);
        cyc_n++;
        for (int m = 0; m < 2; m++) model_step(m);
        #1;
        for (int m = 0; m < 2; m++) check_dut(m);
        if (!cs0 && !ad0) rtc_addr = dd0;
        din = rtc_mode ? (8'hA0 + (rtc_addr - 8'h21)) : 8'($urandom);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr_cnt();
        for (int m = 0; m < 2; m++) begin
            tesc_cnt[m] = 0;
            tlec_cnt[m] = 0;
        end
    endtask

    initial begin : main
        int k, t0, t1;
        bit found;
        for (int m = 0; m < 2; m++) model_reset(m);
        clr_cnt();

        // Reset state
        cycles(3);
        rst = 1'b0;
        cycles(2);
        chk("rst_datos_lec", 64'(lec0), 64'(0));
        chk("rst_strobes", 64'({cs0, wr0, rd0, ad0, oe0, ocu0}), 64'(6'b111100));

        // Directed write with the reference data set; latency on both DUTs
        dat_esc = {8'h16, 8'h09, 8'h08, 8'h03, 8'h34, 8'h00};
        clr_cnt();
        k = cyc_n; t0 = -1; t1 = -1;
        esc = 1'b1;
        for (int i = 0; i < 150; i++) begin
            cyc();
            dat_esc = 48'({$urandom, $urandom});
            if (te0 && t0 < 0) t0 = cyc_n - k;
            if (te1 && t1 < 0) t1 = cyc_n - k;
        end
        chk("lat_esc_default", 64'(t0), 64'(97));
        chk("lat_esc_min", 64'(t1), 64'(5));
        chk("one_term_esc", 64'(tesc_cnt[0]), 64'(1));
        esc = 1'b0;
        cycles(3);

        // Directed read with bus model returning A0+i
        rtc_mode = 1'b1;
        clr_cnt();
        lec = 1'b1;
        cycles(110);
        lec = 1'b0;
        chk("read_bytes", 64'(lec0), 64'(48'hA5A4A3A2A1A0));
        chk("one_term_lec", 64'(tlec_cnt[0]), 64'(1));
        rtc_mode = 1'b0;
        cycles(3);

        // Held Escritura: one burst only
        clr_cnt();
        esc = 1'b1;
        cycles(200);
        esc = 1'b0;
        chk("held_term_esc0", 64'(tesc_cnt[0]), 64'(1));
        chk("held_term_esc1", 64'(tesc_cnt[1]), 64'(1));
        cycles(3);

        // Coincident requests: write wins; mid-burst Lectura edge ignored
        clr_cnt();
        esc = 1'b1; lec = 1'b1;
        cycles(30);
        lec = 1'b0;
        cycles(10);
        lec = 1'b1;
        cycles(70);
        esc = 1'b0; lec = 1'b0;
        chk("tie_term_esc", 64'(tesc_cnt[0]), 64'(1));
        chk("tie_term_lec", 64'(tlec_cnt[0]), 64'(0));
        cycles(10);

        // Randomized requests and write data
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) esc = ~esc;
            if ($urandom_range(0, 19) == 0) lec = ~lec;
            dat_esc = 48'({$urandom, $urandom});
            cyc();
        end
        esc = 1'b0; lec = 1'b0;
        cycles(120);

        // Reset during the third read data phase, then restart
        rtc_mode = 1'b1;
        lec = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (m_busy[0] && !m_wr[0] && m_pos[0] == 41) found = 1'b1;
        end
        chk("reach_third_dat_act", 64'(found), 64'(1));
        chk("pre_reset_partial", 64'(lec0[15:0]), 64'(16'hA1A0));
        #2 rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) model_reset(m);
        chk("async_rst_strobes", 64'({cs0, wr0, rd0, ad0, oe0, ocu0, te0, tl0}), 64'(8'b11110000));
        chk("async_rst_bus", 64'(dd0), 64'(8'h00));
        chk("async_rst_lec", 64'(lec0), 64'(0));
        rtc_mode = 1'b0;
        lec = 1'b0;
        esc = 1'b1;
        cycles(2);
        rst = 1'b0;
        cyc();
        chk("restart_addr", 64'(dd0), 64'(8'h21));
        chk("restart_busy", 64'(ocu0), 64'(1));
        clr_cnt();
        cycles(100);
        chk("restart_term", 64'(tesc_cnt[0]), 64'(1));
        esc = 1'b0;
        cycles(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maquina_rtc_rw.md
MAQUINA_RTC_RW -- requirements
Module: maquina_rtc_rw

Interface
REQ-001 Parameter N_REG, default 6: number of RTC registers moved per transaction burst (1..16).
REQ-002 Parameter T_FASE, default 4: clock cycles per bus phase (1..255).
REQ-003 Parameter DIR_TABLA, default {8'h26,8'h25,8'h24,8'h23,8'h22,8'h21}, N_REG*8 bits: RTC address of register i in bits [8i+7:8i].
REQ-004 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port Escritura, input, 1: write-burst request; acts on its rising edge only.
REQ-007 Port Lectura, input, 1: read-burst request; acts on its rising edge only.
REQ-008 Port Datos_Esc, input, N_REG*8: write data; byte i goes to DIR_TABLA byte i (default order Seg, Min, Hora, Dia, Mes, Ano).
REQ-009 Port Dato_Dire_in, input, 8: bus value sampled during read data phase.
REQ-010 Port CS, WR, RD, AD, output, 1 each: active-low RTC bus strobes; AD=0 marks address phase.
REQ-011 Port Dato_Dire, output, 8: address/data driven onto the multiplexed bus.
REQ-012 Port Dato_oe, output, 1: 1 = Dato_Dire drives the bus.
REQ-013 Port Datos_Lec, output, N_REG*8: bytes captured by the last read burst, same byte mapping as Datos_Esc.
REQ-014 Port Ocupado, Term_Esc, Term_Lec, output, 1 each: burst in progress; one-cycle write-done pulse; one-cycle read-done pulse.

Function
REQ-015 Edge detect: a request is Escritura (or Lectura) = 1 in a cycle where the registered previous value = 0; a held level SHALL NOT retrigger.
REQ-016 States: IDLE, DIR_ACT, DIR_REC, DAT_ACT, DAT_REC, FIN; each of DIR_ACT, DIR_REC, DAT_ACT, DAT_REC lasts exactly T_FASE cycles via a phase counter.
REQ-017 IDLE: on a request, latch Datos_Esc (write) into a snapshot register, set mode, index i=0, go to DIR_ACT next cycle; if write and read requests coincide, write wins and the read request is dropped.
REQ-018 DIR_ACT: CS=0, WR=0, AD=0, RD=1, Dato_Dire=DIR_TABLA byte i, Dato_oe=1.
REQ-019 DIR_REC and DAT_REC: CS=WR=RD=AD=1, Dato_oe=0, Dato_Dire=0.
REQ-020 DAT_ACT write: CS=0, WR=0, AD=1, RD=1, Dato_Dire=snapshot byte i, Dato_oe=1.
REQ-021 DAT_ACT read: CS=0, RD=0, AD=1, WR=1, Dato_oe=0; Dato_Dire_in sampled into Datos_Lec byte i on the last DAT_ACT cycle only.
REQ-022 DAT_REC end: if i<N_REG-1 then i=i+1 and go to DIR_ACT, else go to FIN.
REQ-023 FIN: one cycle; Term_Esc=1 (write) or Term_Lec=1 (read); next state IDLE.
REQ-024 Ocupado=1 in every state except IDLE.
REQ-025 Latency: request edge seen in cycle k -> DIR_ACT starts k+1 -> Term pulse at cycle k+1+4*T_FASE*N_REG.
REQ-026 Requests arriving while Ocupado=1 SHALL be ignored, not queued; edge history keeps updating.
REQ-027 Changes on Datos_Esc during a burst SHALL NOT affect the bytes written.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.
REQ-029 Datos_Lec bytes not yet captured in an aborted or in-progress read keep their previous value.

Reset
REQ-030 Reset SHALL force IDLE, CS=WR=RD=AD=1, Dato_Dire=0, Dato_oe=0, Datos_Lec=0, Ocupado=0, Term_Esc=Term_Lec=0, edge-history registers=0, counters=0, immediately, including mid-burst.
REQ-031 After reset release, an Escritura or Lectura already high SHALL count as a rising edge in the first clocked cycle.

Verification
REQ-032 Defaults, Datos_Esc={8'h16,8'h09,8'h08,8'h03,8'h34,8'h00}, Escritura rises -> bus shows addr/data pairs 21/00, 22/34, 23/03, 24/08, 25/09, 26/16; each strobe low exactly 4 cycles; Term_Esc pulse 97 cycles after edge.
REQ-033 Lectura rises, bench RTC model returns 8'hA0+i in read phase i -> Datos_Lec={A5,A4,A3,A2,A1,A0}; RD low 4 cycles per phase; WR stays 1; Dato_oe=0 in every data phase; Term_Lec pulses once.
REQ-034 Escritura held high for 200 cycles -> exactly one write burst and one Term_Esc pulse.
REQ-035 Escritura and Lectura rise in the same cycle -> write burst only; no Term_Lec pulse; Lectura rising mid-burst ignored.
REQ-036 Reset asserted during third DAT_ACT of a read -> outputs at reset values within the same cycle; Datos_Lec=0; Escritura edge after release starts a clean burst at address 21.
REQ-037 N_REG=1, T_FASE=1 -> burst takes 4 cycles; Term pulse at k+5.
